// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared loader state type and default frame/base constants
package program_loader_pkg;

    localparam logic [31:0] DEF_BASE_ADDR = 32'hBFC0_0000;
    localparam int          DEF_MAX_WORDS = 1024;
    localparam logic [7:0]  DEF_MAGIC     = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } loader_state_t;

    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
        return base + {14'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// program_loader_if: byte stream in, instruction memory write port and status out
interface program_loader_if;

    logic [7:0]  data;
    logic        valid;
    logic        ready;
    logic        clear;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [15:0] word_count;

    modport master (
        output data, valid, clear,
        input  ready, wr_en, wr_addr, wr_data, cpu_hold, done, error, word_count
    );

    modport slave (
        input  data, valid, clear,
        output ready, wr_en, wr_addr, wr_data, cpu_hold, done, error, word_count
    );

endinterface

// File: rtl/program_loader_word_assembler.sv
// program_loader_word_assembler: packs little-endian bytes into words, keeps running XOR
module program_loader_word_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  byte_in,
    output logic        last,
    output logic        word_ready,
    output logic [31:0] word,
    output logic [7:0]  chk
);

    logic [1:0] idx;

    assign last = en && idx == 2'd3;

    // byte lanes, checksum and a one-cycle ready pulse after the fourth byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            word       <= '0;
            chk        <= '0;
            word_ready <= 1'b0;
        end else begin
            word_ready <= last;
            if (clr) begin
                idx <= '0;
                chk <= '0;
            end else if (en) begin
                word[{idx, 3'b000} +: 8] <= byte_in;
                chk                      <= chk ^ byte_in;
                idx                      <= idx + 2'd1;
            end
        end
    end

endmodule

// File: rtl/program_loader.sv
// program_loader: parses a framed byte stream and writes the image into instruction memory
module program_loader
    import program_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int          MAX_WORDS = DEF_MAX_WORDS,
    parameter logic [7:0]  MAGIC     = DEF_MAGIC
) (
    input  logic             clk,
    input  logic             rst_n,
    program_loader_if.slave  bus
);

    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    loader_state_t state, nxt;
    logic [15:0]   len_q, len, word_count;
    logic [31:0]   wr_addr, word;
    logic [7:0]    chk;
    logic          xfer, clr, last, word_ready, ready, done, error, cpu_hold;

    assign xfer = bus.valid && ready;
    assign clr  = xfer && state == S_LEN_HI;
    assign len  = {bus.data, len_q[7:0]};

    program_loader_word_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .en         (xfer && state == S_DATA),
        .byte_in    (bus.data),
        .last       (last),
        .word_ready (word_ready),
        .word       (word),
        .chk        (chk)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nxt;
    end

    // frame parsing; a MAGIC byte inside DATA is ordinary payload
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:          nxt = (xfer && bus.data == MAGIC) ? S_LEN_LO : S_IDLE;
            S_LEN_LO:        nxt = xfer ? S_LEN_HI : S_LEN_LO;
            S_LEN_HI:        nxt = !xfer ? S_LEN_HI : ({1'b0, len} > MAX_W) ? S_ERROR : (len == 16'd0) ? S_CHECK : S_DATA;
            S_DATA:          nxt = (last && word_count + 16'd1 == len_q) ? S_CHECK : S_DATA;
            S_CHECK:         nxt = !xfer ? S_CHECK : (bus.data == chk) ? S_DONE : S_ERROR;
            S_DONE, S_ERROR: nxt = bus.clear ? S_IDLE : state;
            default:         nxt = S_IDLE;
        endcase
    end

    // status outputs depend on state only, so ready never follows valid
    always_comb begin
        ready    = state != S_DONE && state != S_ERROR;
        done     = state == S_DONE;
        error    = state == S_ERROR;
        cpu_hold = state != S_DONE;
    end

    // length capture, word counter and write address for the pending word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q      <= '0;
            word_count <= '0;
            wr_addr    <= BASE_ADDR;
        end else begin
            if (xfer && state == S_LEN_LO) len_q[7:0]  <= bus.data;
            if (clr)                       len_q[15:8] <= bus.data;
            if (clr) begin
                word_count <= '0;
            end else if (last) begin
                word_count <= word_count + 16'd1;
                wr_addr    <= word_addr(BASE_ADDR, word_count);
            end
        end
    end

    assign bus.ready      = ready;
    assign bus.done       = done;
    assign bus.error      = error;
    assign bus.cpu_hold   = cpu_hold;
    assign bus.wr_en      = word_ready;
    assign bus.wr_addr    = wr_addr;
    assign bus.wr_data    = word;
    assign bus.word_count = word_count;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: random frames against a frame-level model with a write scoreboard
module tb_program_loader;
    import program_loader_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    program_loader_if bus();

    program_loader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int passes = 0;
    int total  = 0;
    bit gaps   = 0;
    logic [31:0] img[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [15:0] exp_cnt[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (rst_n && bus.wr_en) begin
            if (exp_addr.size() == 0) begin
                chk("unexpected_write_addr", bus.wr_addr, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                chk("wr_addr", bus.wr_addr, exp_addr.pop_front());
                chk("wr_data", bus.wr_data, exp_data.pop_front());
                chk("wr_count", bus.word_count, exp_cnt.pop_front());
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int w = 0;
        while (gaps && $urandom_range(1) == 0) begin
            bus.valid = 1'b0;
            bus.clear = 1'($urandom_range(1));
            @(negedge clk);
            chk("ready_while_idle", bus.ready, 1);
        end
        bus.clear = 1'b0;
        while (!bus.ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("ready", bus.ready, 1);
        bus.data  = b;
        bus.valid = 1'b1;
        @(negedge clk);
        bus.valid = 1'b0;
    endtask

    task automatic fill_img(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back($urandom());
    endtask

    task automatic check_reset_values();
        chk("rst_ready", bus.ready, 1);
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_wr_addr", bus.wr_addr, DEF_BASE_ADDR);
        chk("rst_wr_data", bus.wr_data, 0);
        chk("rst_cpu_hold", bus.cpu_hold, 1);
        chk("rst_done", bus.done, 0);
        chk("rst_error", bus.error, 0);
        chk("rst_word_count", bus.word_count, 0);
    endtask

    // sends MAGIC, header n, the words of img and checksum^delta, then checks the outcome
    task automatic run_frame(input int n, input logic [7:0] delta);
        logic [15:0] n16 = 16'(n);
        logic [7:0]  c = 8'h00;
        bit bad = n > DEF_MAX_WORDS;
        bit ok  = !bad && delta == 8'h00;
        send_byte(DEF_MAGIC);
        send_byte(n16[7:0]);
        send_byte(n16[15:8]);
        if (!bad) begin
            for (int i = 0; i < n; i++) begin
                exp_addr.push_back(DEF_BASE_ADDR + 32'(4 * i));
                exp_data.push_back(img[i]);
                exp_cnt.push_back(16'(i + 1));
            end
            for (int i = 0; i < n; i++)
                for (int k = 0; k < 4; k++) begin
                    c ^= img[i][8*k +: 8];
                    send_byte(img[i][8*k +: 8]);
                end
            send_byte(c ^ delta);
        end
        chk("done", bus.done, ok);
        chk("error", bus.error, !ok);
        chk("cpu_hold", bus.cpu_hold, !ok);
        chk("ready_after_frame", bus.ready, 0);
        chk("word_count", bus.word_count, bad ? 0 : n);
        chk("writes_pending", exp_addr.size(), 0);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        chk("clear_ready", bus.ready, 1);
        chk("clear_done", bus.done, 0);
        chk("clear_error", bus.error, 0);
        chk("clear_cpu_hold", bus.cpu_hold, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.data  = 8'h00;
        bus.valid = 1'b0;
        bus.clear = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        @(negedge clk);

        img = '{32'h0000_0013, 32'h0010_0093};
        run_frame(2, 8'h00);

        send_byte(8'h00);
        send_byte(8'hFF);
        img = '{32'hDEAD_BEEF};
        run_frame(1, 8'h00);

        img.delete();
        run_frame(0, 8'h00);
        run_frame(1025, 8'h00);

        fill_img(3);
        run_frame(3, 8'h01);

        fill_img(16);
        run_frame(16, 8'h00);
        gaps = 1;
        run_frame(16, 8'h00);

        for (int r = 0; r < 4; r++) begin
            int n = $urandom_range(1, 8);
            fill_img(n);
            run_frame(n, ($urandom_range(1) == 0) ? 8'h00 : 8'(1 << $urandom_range(7)));
        end
        gaps = 0;

        fill_img(DEF_MAX_WORDS);
        run_frame(DEF_MAX_WORDS, 8'h00);

        fill_img(4);
        send_byte(DEF_MAGIC);
        send_byte(8'h04);
        send_byte(8'h00);
        for (int i = 0; i < 3; i++) begin
            exp_addr.push_back(DEF_BASE_ADDR + 32'(4 * i));
            exp_data.push_back(img[i]);
            exp_cnt.push_back(16'(i + 1));
        end
        for (int j = 0; j < 14; j++) send_byte(img[j / 4][8*(j % 4) +: 8]);
        chk("partial_writes_pending", exp_addr.size(), 0);
        rst_n = 1'b0;
        #1;
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
        fill_img(5);
        run_frame(5, 8'h00);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
